// File: rtl/rename_stage_pkg.sv
// Shared constants and types for the rename stage.
//   PR_ADDR_W : physical register index width (N_PHYS = 1 << PR_ADDR_W)
//   ARCH_W    : architectural register field width
//   HARD_REGS : arch/phys registers 0 and 1 are hardwired and never renamed
//   N_ARCH    : architectural registers including the hardwired pair
//   N_SRC     : source slots per microop
//   N_DST     : destination slots per microop
package rename_stage_pkg;

    localparam int PR_ADDR_W = 5;
    localparam int N_PHYS    = 1 << PR_ADDR_W;
    localparam int ARCH_W    = 4;
    localparam int HARD_REGS = 2;
    localparam int N_ARCH    = 12;
    localparam int N_SRC     = 4;
    localparam int N_DST     = 2;

    typedef logic [PR_ADDR_W-1:0] pr_t;
    typedef logic [ARCH_W-1:0]    arch_t;

    // Arch registers below HARD_REGS read as constants and carry no destination.
    function automatic logic is_renamed(arch_t a);
        return a >= arch_t'(HARD_REGS);
    endfunction

    // Hardwired physical registers never return to the free mask.
    function automatic logic is_recyclable(pr_t p);
        return p >= pr_t'(HARD_REGS);
    endfunction

endpackage

// File: rtl/rename_stage_if.sv
// Bus bundle for the rename stage: decode-side input handshake, reservation
// station output handshake, writeback broadcast, retire port and flush.
//   slave  : the rename stage itself
//   master : the surrounding pipeline (decode, RS, ROB, writeback)
interface rename_stage_if;
    import rename_stage_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [ARCH_W*N_SRC-1:0]     in_src_arch;
    logic [ARCH_W*N_DST-1:0]     in_dst_arch;

    logic                        out_valid;
    logic                        out_ready;
    logic [PR_ADDR_W*N_SRC-1:0]  out_src_phys;
    logic [N_SRC-1:0]            out_src_ready;
    logic [PR_ADDR_W*N_DST-1:0]  out_dst_phys;
    logic [PR_ADDR_W*N_DST-1:0]  out_dst_old;

    logic                        wb_valid;
    logic [PR_ADDR_W-1:0]        wb_phys;

    logic [N_DST-1:0]            ret_valid;
    logic [ARCH_W*N_DST-1:0]     ret_arch;
    logic [PR_ADDR_W*N_DST-1:0]  ret_phys;
    logic [PR_ADDR_W*N_DST-1:0]  ret_old;

    logic                        flush;

    modport slave (
        input  in_valid, in_src_arch, in_dst_arch, out_ready,
               wb_valid, wb_phys, ret_valid, ret_arch, ret_phys, ret_old, flush,
        output in_ready, out_valid, out_src_phys, out_src_ready, out_dst_phys, out_dst_old
    );

    modport master (
        output in_valid, in_src_arch, in_dst_arch, out_ready,
               wb_valid, wb_phys, ret_valid, ret_arch, ret_phys, ret_old, flush,
        input  in_ready, out_valid, out_src_phys, out_src_ready, out_dst_phys, out_dst_old
    );

endinterface

// File: rtl/rename_free_alloc.sv
// Free-list picker: from the free mask, returns the N_DST lowest free physical
// registers (slot 0 = lowest), a valid bit per pick, and the free count.
//   free_mask : one bit per physical register, 1 = free
//   alloc_idx : picked register per allocation slot
//   alloc_vld : pick exists for that slot
//   free_cnt  : population count of free_mask
module rename_free_alloc
    import rename_stage_pkg::*;
(
    input  logic [N_PHYS-1:0]    free_mask,
    output pr_t                  alloc_idx [N_DST],
    output logic [N_DST-1:0]     alloc_vld,
    output logic [PR_ADDR_W:0]   free_cnt
);

    always_comb begin : pick_lowest
        logic [N_PHYS-1:0] remaining;
        logic              found;
        pr_t               idx;
        remaining = free_mask;
        for (int k = 0; k < N_DST; k++) begin
            found = 1'b0;
            idx   = '0;
            for (int i = 0; i < N_PHYS; i++) begin
                if (!found && remaining[i]) begin
                    found = 1'b1;
                    idx   = pr_t'(i);
                end
            end
            // Remove this pick so the next slot sees the next-lowest register.
            if (found) remaining[idx] = 1'b0;
            alloc_idx[k] = idx;
            alloc_vld[k] = found;
        end
    end

    always_comb begin : popcount
        free_cnt = '0;
        for (int i = 0; i < N_PHYS; i++) begin
            free_cnt = free_cnt + (PR_ADDR_W+1)'(free_mask[i]);
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Registered rename stage between decode and the reservation stations.
// Maps source arch regs through the speculative map, allocates fresh physical
// registers for destinations, tracks per-register done bits, returns retired
// registers to the free mask and rebuilds speculative state from the
// committed map on flush.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rename_stage_if.slave (input/output handshakes, wb, retire, flush)
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    rename_stage_if.slave  bus
);

    localparam int CNT_W = PR_ADDR_W + 1;

    pr_t               spec_map   [N_ARCH];
    pr_t               commit_map [N_ARCH];
    logic [N_PHYS-1:0] done;
    logic [N_PHYS-1:0] free_mask;

    pr_t               alloc_idx [N_DST];
    logic [N_DST-1:0]  alloc_vld;
    logic [CNT_W-1:0]  free_cnt;

    pr_t               map_work [N_ARCH];
    pr_t               src_phys [N_SRC];
    logic [N_SRC-1:0]  src_rdy;
    pr_t               dst_new  [N_DST];
    pr_t               dst_old  [N_DST];
    logic [N_PHYS-1:0] alloc_bits;
    logic [CNT_W-1:0]  needed;
    logic              in_ready;
    logic              accept;

    pr_t               commit_nxt [N_ARCH];
    logic [N_PHYS-1:0] free_ret;
    logic [N_PHYS-1:0] flush_free;
    logic [N_PHYS-1:0] done_nxt;

    logic                       vld_p1;
    logic [PR_ADDR_W*N_SRC-1:0] src_phys_p1;
    logic [N_SRC-1:0]           src_rdy_p1;
    logic [PR_ADDR_W*N_DST-1:0] dst_phys_p1;
    logic [PR_ADDR_W*N_DST-1:0] dst_old_p1;

    rename_free_alloc u_free_alloc (
        .free_mask (free_mask),
        .alloc_idx (alloc_idx),
        .alloc_vld (alloc_vld),
        .free_cnt  (free_cnt)
    );

    always_comb begin : rename_comb
        arch_t a;
        pr_t   p;
        int    rank;
        logic  short_pick;
        map_work   = spec_map;
        needed     = '0;
        alloc_bits = '0;
        rank       = 0;
        short_pick = 1'b0;
        // Sources see the map before this microop's own destinations land.
        for (int i = 0; i < N_SRC; i++) begin
            a           = bus.in_src_arch[i*ARCH_W +: ARCH_W];
            p           = is_renamed(a) ? spec_map[a] : pr_t'(a);
            src_phys[i] = p;
            src_rdy[i]  = done[p] | (bus.wb_valid & (bus.wb_phys == p));
        end
        // Destinations take picks in slot order; a repeated arch reg sees the
        // earlier slot's new register as its old mapping.
        for (int k = 0; k < N_DST; k++) begin
            a          = bus.in_dst_arch[k*ARCH_W +: ARCH_W];
            dst_new[k] = '0;
            dst_old[k] = '0;
            if (is_renamed(a)) begin
                for (int j = 0; j < N_DST; j++) begin
                    if (rank == j) begin
                        dst_new[k] = alloc_idx[j];
                        short_pick = short_pick | !alloc_vld[j];
                    end
                end
                rank                   = rank + 1;
                needed                 = needed + CNT_W'(1);
                dst_old[k]             = map_work[a];
                map_work[a]            = dst_new[k];
                alloc_bits[dst_new[k]] = 1'b1;
            end
        end
        in_ready = !rst && (!vld_p1 || bus.out_ready) && (free_cnt >= needed)
                   && !short_pick && !bus.flush;
        accept   = bus.in_valid && in_ready;
    end

    always_comb begin : retire_comb
        arch_t ra;
        pr_t   rp;
        pr_t   ro;
        commit_nxt = commit_map;
        free_ret   = free_mask;
        // Slot 1 applies after slot 0 so it wins on a shared arch reg.
        for (int k = 0; k < N_DST; k++) begin
            ra = bus.ret_arch[k*ARCH_W +: ARCH_W];
            rp = bus.ret_phys[k*PR_ADDR_W +: PR_ADDR_W];
            ro = bus.ret_old[k*PR_ADDR_W +: PR_ADDR_W];
            if (bus.ret_valid[k]) begin
                commit_nxt[ra] = rp;
                if (is_recyclable(ro)) free_ret[ro] = 1'b1;
            end
        end
        for (int i = 0; i < N_PHYS; i++) begin
            flush_free[i] = (i >= HARD_REGS);
        end
        for (int i = 0; i < N_ARCH; i++) begin
            flush_free[commit_nxt[i]] = 1'b0;
        end
        // Allocation clears done after writeback sets it: a same-cycle
        // writeback to a just-allocated register belongs to a stale producer.
        done_nxt = done;
        if (bus.wb_valid) done_nxt[bus.wb_phys] = 1'b1;
        if (accept) done_nxt = done_nxt & ~alloc_bits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ARCH; i++) begin
                spec_map[i]   <= pr_t'(i);
                commit_map[i] <= pr_t'(i);
            end
            for (int i = 0; i < N_PHYS; i++) begin
                free_mask[i] <= (i >= N_ARCH);
            end
            done        <= '1;
            vld_p1      <= 1'b0;
            src_phys_p1 <= '0;
            src_rdy_p1  <= '0;
            dst_phys_p1 <= '0;
            dst_old_p1  <= '0;
        end else begin
            commit_map <= commit_nxt;
            if (bus.flush) begin
                spec_map  <= commit_nxt;
                free_mask <= flush_free;
                done      <= '1;
                vld_p1    <= 1'b0;
            end else begin
                done      <= done_nxt;
                free_mask <= accept ? (free_ret & ~alloc_bits) : free_ret;
                if (accept) spec_map <= map_work;

                // ---- stage boundary: rename -> output register (p1) ----
                if (accept) begin
                    vld_p1     <= 1'b1;
                    src_rdy_p1 <= src_rdy;
                    for (int i = 0; i < N_SRC; i++) begin
                        src_phys_p1[i*PR_ADDR_W +: PR_ADDR_W] <= src_phys[i];
                    end
                    for (int k = 0; k < N_DST; k++) begin
                        dst_phys_p1[k*PR_ADDR_W +: PR_ADDR_W] <= dst_new[k];
                        dst_old_p1[k*PR_ADDR_W +: PR_ADDR_W]  <= dst_old[k];
                    end
                end else if (vld_p1 && bus.out_ready) begin
                    vld_p1 <= 1'b0;
                end else if (vld_p1 && bus.wb_valid) begin
                    // Held microop keeps snooping writebacks while stalled.
                    for (int i = 0; i < N_SRC; i++) begin
                        if (src_phys_p1[i*PR_ADDR_W +: PR_ADDR_W] == bus.wb_phys) begin
                            src_rdy_p1[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = vld_p1;
    assign bus.out_src_phys  = src_phys_p1;
    assign bus.out_src_ready = src_rdy_p1;
    assign bus.out_dst_phys  = dst_phys_p1;
    assign bus.out_dst_old   = dst_old_p1;

endmodule
